nibble_serial_add_ctrl: RTL and testbench

// - Sequencer that time-shares one external 4-bit adder slice (a/b/cin -> sum/cout) to add WIDTH-bit operands.
// - Works one nibble per cycle, LSB nibble first, and registers the carry between nibbles.
// - Sits between a requester (start/done handshake) and the adder slice, so wide sums need no wide adder.

---
 rtl/nibble_serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: drives one external 4-bit adder slice, LSB nibble first.
// Optional SUB_MODE_EN adds a sub port for A-B via inverted B and forced initial carry.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    nib_cnt;
  logic             accept;
  logic             init_carry;
  logic             sub_q;
  logic [3:0]       b_nib;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef SUB_MODE_EN
  // Subtract is A + ~B + 1, so the requested cin is overridden.
  assign init_carry = sub ? 1'b1 : cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= sub;
    end
  end
`else
  assign init_carry = cin;
  assign sub_q      = 1'b0;
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    b_nib   = b_q[4*nib_cnt +: 4];
    if (state == RUN) begin
      add_a   = a_q[4*nib_cnt +: 4];
      add_b   = sub_q ? ~b_nib : b_nib;
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      nib_cnt <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= init_carry;
            nib_cnt <= '0;
            result  <= '0;
            cout    <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[4*nib_cnt +: 4] <= add_sum;
          carry_q                <= add_cout;
          if (nib_cnt == LAST) begin
            cout  <= add_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16 plus a WIDTH=4 instance); behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, cout;
  logic [15:0] result;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  logic        n_start = 1'b0;
  logic [3:0]  n_a = '0;
  logic [3:0]  n_b = '0;
  logic        n_cin = 1'b0;
  logic        n_sub = 1'b0;
  logic        n_busy, n_done, n_cout;
  logic [3:0]  n_result;
  logic [3:0]  n_add_a, n_add_b, n_add_sum;
  logic        n_add_cin, n_add_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign {n_add_cout, n_add_sum} = {1'b0, n_add_a} + {1'b0, n_add_b} + {4'b0, n_add_cin};

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUB_MODE_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut_n1 (
    .clk(clk), .rst(rst), .start(n_start), .op_a(n_a), .op_b(n_b), .cin(n_cin),
`ifdef SUB_MODE_EN
    .sub(n_sub),
`endif
    .busy(n_busy), .done(n_done), .result(n_result), .cout(n_cout),
    .add_a(n_add_a), .add_b(n_add_b), .add_cin(n_add_cin),
    .add_sum(n_add_sum), .add_cout(n_add_cout)
  );

  // Accepts one request and waits (bounded) for done; returns first-RUN-cycle slice inputs too.
  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [15:0] r, output logic co, output int nbusy, output int ndone,
                         output logic [3:0] fa, output logic [3:0] fb, output logic fc);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; r = 16'hDEAD; co = 1'bx;
    fa = add_a; fb = add_b; fc = add_cin;
    for (int k = 1; k <= 20; k++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone = k; r = result; co = cout;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    checks++; if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL reset_slice got a=%h b=%h c=%b exp 0 0 0", add_a, add_b, add_cin);
    end
    checks++; if (n_busy !== 1'b0 || n_result !== 4'h0) begin
      errors++; $display("FAIL reset_n1 got busy=%b result=%h exp 0 0", n_busy, n_result);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_basic;
    logic [15:0] r; logic co; int nb, nd; logic [3:0] fa, fb; logic fc;
    run_add(16'h0001, 16'h0002, 1'b0, 1'b0, r, co, nb, nd, fa, fb, fc);
    checks++; if (r !== 16'h0003) begin errors++; $display("FAIL basic_result got %h exp 0003", r); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", co); end
    checks++; if (nb != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 4", nb); end
    checks++; if (nd != 5) begin errors++; $display("FAIL basic_done_latency got %0d exp 5", nd); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (result !== 16'h0003) begin errors++; $display("FAIL basic_result_hold got %h exp 0003", result); end
  endtask

  task automatic test_carry_ripple;
    logic [15:0] r; logic co; int nb, nd; logic [3:0] fa, fb; logic fc;
    run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, co, nb, nd, fa, fb, fc);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL ripple_result got %h exp 0000", r); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b exp 1", co); end
    checks++; if (nd != 5) begin errors++; $display("FAIL ripple_done_latency got %0d exp 5", nd); end
  endtask

  task automatic test_cin;
    logic [15:0] r; logic co; int nb, nd; logic [3:0] fa, fb; logic fc;
    run_add(16'hABCD, 16'h1234, 1'b1, 1'b0, r, co, nb, nd, fa, fb, fc);
    checks++; if (r !== 16'hBE02) begin errors++; $display("FAIL cin_result got %h exp BE02", r); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL cin_cout got %b exp 0", co); end
    checks++; if (fa !== 4'hD || fb !== 4'h4 || fc !== 1'b1) begin
      errors++; $display("FAIL cin_first_slice got a=%h b=%h c=%b exp D 4 1", fa, fb, fc);
    end
  endtask

  task automatic test_back_to_back;
    int at1, at2; logic [15:0] r1, r2; logic c2;
    at1 = 0; at2 = 0; r1 = 16'hDEAD; r2 = 16'hDEAD; c2 = 1'bx;
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin op_a = 16'h5555; op_b = 16'h0001; end
      if (done) begin at1 = k; r1 = result; break; end
    end
    checks++; if (at1 != 5) begin errors++; $display("FAIL b2b_first_latency got %0d exp 5", at1); end
    checks++; if (r1 !== 16'h3333) begin errors++; $display("FAIL b2b_first_result got %h exp 3333", r1); end
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin at2 = k; r2 = result; c2 = cout; break; end
    end
    start = 1'b0;
    checks++; if (at2 != 5) begin errors++; $display("FAIL b2b_second_latency got %0d exp 5", at2); end
    checks++; if (r2 !== 16'h5556 || c2 !== 1'b0) begin
      errors++; $display("FAIL b2b_second_result got %h/%b exp 5556/0", r2, c2);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    seen = 0;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstrun_done got %b exp 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rstrun_result got %h exp 0000", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rstrun_cout got %b exp 0", cout); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstrun_no_done got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_nib1;
    logic fa_ok;
    @(negedge clk);
    n_a = 4'hF; n_b = 4'h1; n_cin = 1'b0; n_sub = 1'b0; n_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_start = 1'b0;
    fa_ok = (n_add_a === 4'hF);
    checks++; if (n_busy !== 1'b1 || !fa_ok) begin
      errors++; $display("FAIL n1_run got busy=%b add_a=%h exp 1 F", n_busy, n_add_a);
    end
    @(negedge clk);
    checks++; if (n_done !== 1'b1 || n_result !== 4'h0 || n_cout !== 1'b1) begin
      errors++; $display("FAIL n1_done got done=%b result=%h cout=%b exp 1 0 1", n_done, n_result, n_cout);
    end
  endtask

`ifdef SUB_MODE_EN
  task automatic test_sub;
    logic [15:0] r; logic co; int nb, nd; logic [3:0] fa, fb; logic fc;
    run_add(16'h0005, 16'h0007, 1'b0, 1'b1, r, co, nb, nd, fa, fb, fc);
    checks++; if (r !== 16'hFFFE || co !== 1'b0) begin
      errors++; $display("FAIL sub_borrow got %h/%b exp FFFE/0", r, co);
    end
    run_add(16'h0007, 16'h0005, 1'b0, 1'b1, r, co, nb, nd, fa, fb, fc);
    checks++; if (r !== 16'h0002 || co !== 1'b1) begin
      errors++; $display("FAIL sub_noborrow got %h/%b exp 0002/1", r, co);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_carry_ripple();
    test_cin();
    test_back_to_back();
    test_reset_mid_run();
    test_nib1();
`ifdef SUB_MODE_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
